// File: rtl/gem_sync_err_pkg.sv
`default_nettype none
// ============================================================================
// gem_sync_err_pkg : shared state encoding and default sizes for the
//                    GEM sync-error counter block.
// Revision: 1.0
// ============================================================================
package gem_sync_err_pkg;

  typedef enum logic [1:0] {
    ST_SYNCED  = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_LOST    = 2'd2,
    ST_RECOVER = 2'd3
  } sync_state_t;

  localparam int unsigned C_LOST_THRESH_DEF = 8;
  localparam int unsigned C_HOLD_GOOD_DEF   = 16;
  localparam int unsigned C_EPI_W_DEF       = 16;
  localparam int unsigned C_BAD_W_DEF       = 24;
  localparam int unsigned C_RUN_W           = 8;
  localparam int unsigned C_NUM_CHAN        = 3;

endpackage
`default_nettype wire

// File: rtl/gem_sync_err_chan.sv
`default_nettype none
// ============================================================================
// gem_sync_err_chan : one sync channel - input double register, loss FSM,
//                     saturating episode / bad-cycle counters and alarms.
// Revision: 1.0
// ============================================================================
module gem_sync_err_chan
  import gem_sync_err_pkg::*;
#(
  parameter int unsigned LOST_THRESH = C_LOST_THRESH_DEF,
  parameter int unsigned HOLD_GOOD   = C_HOLD_GOOD_DEF,
  parameter int unsigned EPI_W       = C_EPI_W_DEF,
  parameter int unsigned BAD_W       = C_BAD_W_DEF
) (
  input  logic             clock,
  input  logic             global_reset_n,
  input  logic             i_clear,
  input  logic             i_count_en,
  input  logic             i_synced,
  output logic [EPI_W-1:0] o_cnt_episode,
  output logic [BAD_W-1:0] o_cnt_bad,
  output sync_state_t      o_state,
  output logic             o_alarm,
  output logic             o_alarm_latched
);

  localparam logic [C_RUN_W-1:0] c_lost_thresh = C_RUN_W'(LOST_THRESH);
  localparam logic [C_RUN_W-1:0] c_hold_good   = C_RUN_W'(HOLD_GOOD);

  logic               r_s1;
  logic               r_s2;
  sync_state_t        r_state;
  logic [C_RUN_W-1:0] r_run;
  logic [EPI_W-1:0]   r_cnt_episode;
  logic [BAD_W-1:0]   r_cnt_bad;
  logic               r_alarm;
  logic               r_alarm_latched;

  logic w_episode;
  logic w_bad;
  logic w_enter_lost;

  assign w_episode = r_s2 & ~r_s1;
  assign w_bad     = ~r_s1;

  // Every path into LOST is taken on a bad sample from a non-LOST state.
  assign w_enter_lost = w_bad &
                        (((r_state == ST_SYNCED) && (LOST_THRESH == 1)) ||
                         ((r_state == ST_SUSPECT) && (r_run + 8'd1 == c_lost_thresh)) ||
                         (r_state == ST_RECOVER));

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_synced;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_state <= ST_SYNCED;
      r_run   <= '0;
      r_alarm <= 1'b0;
    end else begin
      case (r_state)
        ST_SYNCED: begin
          if (!r_s1) begin
            if (LOST_THRESH == 1) begin
              r_state <= ST_LOST;
              r_run   <= '0;
              r_alarm <= 1'b1;
            end else begin
              r_state <= ST_SUSPECT;
              r_run   <= 8'd1;
            end
          end
        end
        ST_SUSPECT: begin
          if (r_s1) begin
            r_state <= ST_SYNCED;
            r_run   <= '0;
          end else if (r_run + 8'd1 == c_lost_thresh) begin
            r_state <= ST_LOST;
            r_run   <= '0;
            r_alarm <= 1'b1;
          end else begin
            r_run <= r_run + 8'd1;
          end
        end
        ST_LOST: begin
          if (r_s1) begin
            r_alarm <= 1'b0;
            if (HOLD_GOOD == 1) begin
              r_state <= ST_SYNCED;
              r_run   <= '0;
            end else begin
              r_state <= ST_RECOVER;
              r_run   <= 8'd1;
            end
          end
        end
        ST_RECOVER: begin
          if (!r_s1) begin
            r_state <= ST_LOST;
            r_run   <= '0;
            r_alarm <= 1'b1;
          end else if (r_run + 8'd1 == c_hold_good) begin
            r_state <= ST_SYNCED;
            r_run   <= '0;
          end else begin
            r_run <= r_run + 8'd1;
          end
        end
        default: begin
          r_state <= ST_SYNCED;
          r_run   <= '0;
          r_alarm <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_cnt_episode   <= '0;
      r_cnt_bad       <= '0;
      r_alarm_latched <= 1'b0;
    end else if (i_clear) begin
      r_cnt_episode   <= '0;
      r_cnt_bad       <= '0;
      r_alarm_latched <= 1'b0;
    end else begin
      if (w_enter_lost) begin
        r_alarm_latched <= 1'b1;
      end
      if (i_count_en) begin
        if (w_episode && (r_cnt_episode != '1)) begin
          r_cnt_episode <= r_cnt_episode + EPI_W'(1);
        end
        if (w_bad && (r_cnt_bad != '1)) begin
          r_cnt_bad <= r_cnt_bad + BAD_W'(1);
        end
      end
    end
  end

  assign o_cnt_episode   = r_cnt_episode;
  assign o_cnt_bad       = r_cnt_bad;
  assign o_state         = r_state;
  assign o_alarm         = r_alarm;
  assign o_alarm_latched = r_alarm_latched;

endmodule
`default_nettype wire

// File: rtl/gem_sync_err_cnt.sv
`default_nettype none
// ============================================================================
// gem_sync_err_cnt : sync-loss statistics for GEM A, GEM B and GEM AB links.
// Revision: 1.0
// ============================================================================
module gem_sync_err_cnt
  import gem_sync_err_pkg::*;
#(
  parameter int unsigned LOST_THRESH = C_LOST_THRESH_DEF,
  parameter int unsigned HOLD_GOOD   = C_HOLD_GOOD_DEF,
  parameter int unsigned EPI_W       = C_EPI_W_DEF,
  parameter int unsigned BAD_W       = C_BAD_W_DEF
) (
  input  logic             clock,
  input  logic             global_reset_n,
  input  logic             ctr_clear,
  input  logic             count_en,
  input  logic             gemA_synced,
  input  logic             gemB_synced,
  input  logic             gems_synced,
  output logic [EPI_W-1:0] cnt_episode0,
  output logic [EPI_W-1:0] cnt_episode1,
  output logic [EPI_W-1:0] cnt_episode2,
  output logic [BAD_W-1:0] cnt_bad0,
  output logic [BAD_W-1:0] cnt_bad1,
  output logic [BAD_W-1:0] cnt_bad2,
  output logic [5:0]       sync_state,
  output logic [2:0]       alarm,
  output logic [2:0]       alarm_latched
);

  logic [C_NUM_CHAN-1:0] w_synced;
  logic [EPI_W-1:0]      w_cnt_episode [C_NUM_CHAN];
  logic [BAD_W-1:0]      w_cnt_bad     [C_NUM_CHAN];
  sync_state_t           w_state       [C_NUM_CHAN];

  assign w_synced = {gems_synced, gemB_synced, gemA_synced};

  generate
    for (genvar g = 0; g < C_NUM_CHAN; g++) begin : g_chan
      gem_sync_err_chan #(
        .LOST_THRESH (LOST_THRESH),
        .HOLD_GOOD   (HOLD_GOOD),
        .EPI_W       (EPI_W),
        .BAD_W       (BAD_W)
      ) u_chan (
        .clock           (clock),
        .global_reset_n  (global_reset_n),
        .i_clear         (ctr_clear),
        .i_count_en      (count_en),
        .i_synced        (w_synced[g]),
        .o_cnt_episode   (w_cnt_episode[g]),
        .o_cnt_bad       (w_cnt_bad[g]),
        .o_state         (w_state[g]),
        .o_alarm         (alarm[g]),
        .o_alarm_latched (alarm_latched[g])
      );
      assign sync_state[2*g+1:2*g] = w_state[g];
    end
  endgenerate

  assign cnt_episode0 = w_cnt_episode[0];
  assign cnt_episode1 = w_cnt_episode[1];
  assign cnt_episode2 = w_cnt_episode[2];
  assign cnt_bad0     = w_cnt_bad[0];
  assign cnt_bad1     = w_cnt_bad[1];
  assign cnt_bad2     = w_cnt_bad[2];

endmodule
`default_nettype wire

// File: tb/tb_gem_sync_err_cnt.sv
`default_nettype none
// ============================================================================
// tb_gem_sync_err_cnt : directed scenarios plus random sync traffic, checked
//                       every cycle against a run-length reference model.
// Revision: 1.0
// ============================================================================
module tb_gem_sync_err_cnt;

  localparam int LT = 8;
  localparam int HG = 16;
  localparam int EW = 16;
  localparam int BW = 24;
  localparam longint EPI_MAX = (64'd1 << EW) - 1;
  localparam longint BAD_MAX = (64'd1 << BW) - 1;

  logic          clock = 1'b0;
  logic          global_reset_n = 1'b1;
  logic          ctr_clear = 1'b0;
  logic          count_en = 1'b1;
  logic          gemA_synced = 1'b1;
  logic          gemB_synced = 1'b1;
  logic          gems_synced = 1'b1;
  logic [EW-1:0] cnt_episode0, cnt_episode1, cnt_episode2;
  logic [BW-1:0] cnt_bad0, cnt_bad1, cnt_bad2;
  logic [5:0]    sync_state;
  logic [2:0]    alarm, alarm_latched;

  int checks = 0;
  int errors = 0;

  gem_sync_err_cnt #(
    .LOST_THRESH (LT),
    .HOLD_GOOD   (HG),
    .EPI_W       (EW),
    .BAD_W       (BW)
  ) dut (
    .clock          (clock),
    .global_reset_n (global_reset_n),
    .ctr_clear      (ctr_clear),
    .count_en       (count_en),
    .gemA_synced    (gemA_synced),
    .gemB_synced    (gemB_synced),
    .gems_synced    (gems_synced),
    .cnt_episode0   (cnt_episode0),
    .cnt_episode1   (cnt_episode1),
    .cnt_episode2   (cnt_episode2),
    .cnt_bad0       (cnt_bad0),
    .cnt_bad1       (cnt_bad1),
    .cnt_bad2       (cnt_bad2),
    .sync_state     (sync_state),
    .alarm          (alarm),
    .alarm_latched  (alarm_latched)
  );

  always #5 clock = ~clock;

  // Reference model: the FSM is tracked as a lost flag plus lengths of the
  // current runs of bad and good samples.
  bit     m_s1 [3];
  bit     m_s2 [3];
  bit     m_lost [3];
  bit     m_latched [3];
  int     m_bad_run [3];
  int     m_good_run [3];
  longint m_epi [3];
  longint m_badc [3];

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_val(input int ch);
    case (ch)
      0:       return gemA_synced;
      1:       return gemB_synced;
      default: return gems_synced;
    endcase
  endfunction

  function automatic longint dut_epi(input int ch);
    case (ch)
      0:       return longint'(cnt_episode0);
      1:       return longint'(cnt_episode1);
      default: return longint'(cnt_episode2);
    endcase
  endfunction

  function automatic longint dut_bad(input int ch);
    case (ch)
      0:       return longint'(cnt_bad0);
      1:       return longint'(cnt_bad1);
      default: return longint'(cnt_bad2);
    endcase
  endfunction

  function automatic int exp_state(input int ch);
    if (!m_lost[ch]) return (m_bad_run[ch] == 0) ? 0 : 1;
    return (m_good_run[ch] == 0) ? 2 : 3;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      m_s1[ch] = 1'b1;       m_s2[ch] = 1'b1;
      m_lost[ch] = 1'b0;     m_latched[ch] = 1'b0;
      m_bad_run[ch] = 0;     m_good_run[ch] = 0;
      m_epi[ch] = 0;         m_badc[ch] = 0;
    end
  endtask

  task automatic model_edge();
    for (int ch = 0; ch < 3; ch++) begin
      bit bad, epi, enter;
      bad   = !m_s1[ch];
      epi   = m_s2[ch] && !m_s1[ch];
      enter = 1'b0;
      if (bad) begin
        if (m_lost[ch] && m_good_run[ch] > 0) enter = 1'b1;
        m_bad_run[ch]++;
        m_good_run[ch] = 0;
        if (!m_lost[ch] && m_bad_run[ch] >= LT) begin
          m_lost[ch] = 1'b1;
          enter = 1'b1;
        end
      end else begin
        m_bad_run[ch] = 0;
        if (m_lost[ch]) begin
          m_good_run[ch]++;
          if (m_good_run[ch] >= HG) begin
            m_lost[ch] = 1'b0;
            m_good_run[ch] = 0;
          end
        end
      end
      if (ctr_clear) begin
        m_epi[ch] = 0;
        m_badc[ch] = 0;
        m_latched[ch] = 1'b0;
      end else begin
        if (enter) m_latched[ch] = 1'b1;
        if (count_en) begin
          if (epi && m_epi[ch] < EPI_MAX) m_epi[ch]++;
          if (bad && m_badc[ch] < BAD_MAX) m_badc[ch]++;
        end
      end
      m_s2[ch] = m_s1[ch];
      m_s1[ch] = in_val(ch);
    end
  endtask

  task automatic check_all();
    for (int ch = 0; ch < 3; ch++) begin
      chk_val($sformatf("state%0d", ch), 64'(sync_state[2*ch +: 2]), 64'(exp_state(ch)));
      chk_val($sformatf("alarm%0d", ch), 64'(alarm[ch]), 64'(exp_state(ch) == 2));
      chk_val($sformatf("alarm_latched%0d", ch), 64'(alarm_latched[ch]), 64'(m_latched[ch]));
      chk_val($sformatf("cnt_episode%0d", ch), 64'(dut_epi(ch)), 64'(m_epi[ch]));
      chk_val($sformatf("cnt_bad%0d", ch), 64'(dut_bad(ch)), 64'(m_badc[ch]));
    end
  endtask

  task automatic tick(input bit a, input bit b, input bit s, input bit clr, input bit en);
    gemA_synced = a; gemB_synced = b; gems_synced = s;
    ctr_clear = clr; count_en = en;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic run(input bit a, input bit b, input bit s, input int n);
    for (int i = 0; i < n; i++) tick(a, b, s, 1'b0, 1'b1);
  endtask

  initial begin
    longint e_before;
    int     rem [3];
    bit     lvl [3];

    model_reset();
    #1 global_reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_all();
    global_reset_n = 1'b1;

    // Short episode on A: three bad cycles, no loss.
    run(0, 1, 1, 3);
    run(1, 1, 1, 4);
    chk_val("single_episode0", 64'(cnt_episode0), 64'd1);
    chk_val("single_bad0", 64'(cnt_bad0), 64'd3);

    // Loss on B followed by full recovery.
    run(1, 0, 1, 10);
    chk_val("loss_alarm1", 64'(alarm[1]), 64'd1);
    run(1, 1, 1, 18);
    chk_val("recover_state1", 64'(sync_state[3:2]), 64'd0);
    chk_val("recover_alarm1", 64'(alarm[1]), 64'd0);
    chk_val("recover_latched1", 64'(alarm_latched[1]), 64'd1);

    // Interrupted recovery on AB.
    run(1, 1, 0, 10);
    run(1, 1, 1, 5);
    e_before = dut_epi(2);
    run(1, 1, 0, 1);
    run(1, 1, 1, 1);
    chk_val("interrupt_state2", 64'(sync_state[5:4]), 64'd2);
    chk_val("interrupt_epi2_delta", 64'(dut_epi(2) - e_before), 64'd1);
    run(1, 1, 1, 20);

    // Saturation of the bad-cycle counter.
    force dut.g_chan[0].u_chan.r_cnt_bad = 24'hFFFFFE;
    #1 release dut.g_chan[0].u_chan.r_cnt_bad;
    m_badc[0] = 64'hFFFFFE;
    run(0, 1, 1, 5);
    run(1, 1, 1, 2);
    chk_val("saturate_bad0", 64'(cnt_bad0), 64'hFFFFFF);
    run(1, 1, 1, 8);

    // Clear colliding with an episode edge, then frozen counting.
    tick(0, 1, 1, 1'b0, 1'b1);
    tick(1, 1, 1, 1'b1, 1'b1);
    chk_val("clear_epi0", 64'(cnt_episode0), 64'd0);
    chk_val("clear_bad0", 64'(cnt_bad0), 64'd0);
    chk_val("clear_latched", 64'(alarm_latched), 64'd0);
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 1'b0, 1'b0);
    chk_val("frozen_bad0", 64'(cnt_bad0), 64'd0);
    chk_val("frozen_state0", 64'(sync_state[1:0]), 64'd1);
    run(1, 1, 1, 4);

    // Asynchronous reset in the middle of a loss.
    run(1, 0, 1, 10);
    chk_val("pre_reset_alarm1", 64'(alarm[1]), 64'd1);
    #2 global_reset_n = 1'b0;
    #1 model_reset();
    check_all();
    gemA_synced = 1'b1; gemB_synced = 1'b1; gems_synced = 1'b1;
    @(negedge clock);
    global_reset_n = 1'b1;
    run(1, 1, 1, 3);
    chk_val("post_reset_epi1", 64'(cnt_episode1), 64'd0);
    chk_val("post_reset_bad1", 64'(cnt_bad1), 64'd0);

    // Random traffic: per-channel alternating runs of random length.
    for (int ch = 0; ch < 3; ch++) begin
      lvl[ch] = 1'b1;
      rem[ch] = int'($urandom_range(1, 20));
    end
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = !lvl[ch];
          rem[ch] = lvl[ch] ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 14));
        end
        rem[ch]--;
      end
      tick(lvl[0], lvl[1], lvl[2], ($urandom % 80) == 0, ($urandom % 8) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gem_sync_err_cnt.md
GEM_SYNC_ERR_CNT -- requirements
Module: gem_sync_err_cnt

Interface
REQ-001 Parameter LOST_THRESH, default 8, meaning consecutive out-of-sync cycles before a channel is declared LOST; legal range 1..255.
REQ-002 Parameter HOLD_GOOD, default 16, meaning consecutive in-sync cycles before a LOST channel returns to SYNCED; legal range 1..255.
REQ-003 Parameter EPI_W, default 16, meaning width of the episode counters.
REQ-004 Parameter BAD_W, default 24, meaning width of the bad-cycle counters.
REQ-005 clock  input  1  LHC clock; all state updates on its rising edge.
REQ-006 global_reset_n  input  1  reset, asynchronous and active-low.
REQ-007 ctr_clear  input  1  synchronous clear of all counters and latched alarms.
REQ-008 count_en  input  1  counter enable; low freezes counters only.
REQ-009 gemA_synced, gemB_synced, gems_synced  input  1 each  sync flags from the GEM sync monitor; channel 0 = A, 1 = B, 2 = AB.
REQ-010 cnt_episode0..2  output  EPI_W each  number of sync-loss episodes per channel.
REQ-011 cnt_bad0..2  output  BAD_W each  number of out-of-sync cycles per channel.
REQ-012 sync_state  output  6  2-bit FSM state per channel, channel n at bits [2n+1:2n].
REQ-013 alarm  output  3  per-channel live alarm, high while the channel is in LOST.
REQ-014 alarm_latched  output  3  per-channel sticky alarm.

Function
REQ-015 Each synced input shall be registered once (s1) and then a second time (s2); all logic shall use s1/s2 only.
REQ-016 An episode shall be s2=1 and s1=0; cnt_episode shall increment at the edge after that condition is registered, if count_en=1.
REQ-017 cnt_bad shall increment every cycle that s1=0 and count_en=1.
REQ-018 A synced input low first sampled at edge t shall produce a counter change at edge t+1, for both counter types.
REQ-019 Both counters shall saturate at all-ones and hold there; they shall not wrap.
REQ-020 ctr_clear=1 shall zero all counters and alarm_latched at the next edge, overriding any simultaneous increment or alarm set.
REQ-021 The FSM encoding shall be SYNCED=0, SUSPECT=1, LOST=2, RECOVER=3; each channel has one FSM with an 8-bit run counter.
REQ-022 In SYNCED: s1=0 shall move the FSM to SUSPECT with run=1.
REQ-023 In SUSPECT: s1=1 shall move the FSM to SYNCED; s1=0 shall increment run, and the FSM shall enter LOST on the edge where run reaches LOST_THRESH.
REQ-024 With LOST_THRESH=1, SYNCED shall go directly to LOST on the first bad sample.
REQ-025 In LOST: s1=1 shall move the FSM to RECOVER with run=1.
REQ-026 In RECOVER: s1=0 shall move the FSM back to LOST; s1=1 shall increment run, and the FSM shall enter SYNCED on the edge where run reaches HOLD_GOOD.
REQ-027 The FSM shall run regardless of count_en and ctr_clear.
REQ-028 alarm shall be registered and equal (state==LOST).
REQ-029 alarm_latched shall set on entry to LOST and hold until ctr_clear or reset.

Reset
REQ-030 global_reset_n low shall asynchronously clear all counters, alarm and alarm_latched to 0, set s1/s2 to 1, and set every FSM to SYNCED with run=0.
REQ-031 Reset deassertion mid-episode shall not create an episode count; counting starts only from the first s2=1/s1=0 pair after reset.

Structure
REQ-032 A shared package gem_sync_err_pkg shall hold the state encoding constants, the default LOST_THRESH/HOLD_GOOD values, and the EPI_W/BAD_W defaults.
REQ-033 The per-channel logic (input registers, FSM, counters, alarms) shall be one sub-module, gem_sync_err_chan, instanced three times by a generate loop.

Verification
REQ-034 Single episode: gemA_synced low for 3 cycles, then high -> cnt_episode0=1, cnt_bad0=3, state0 SYNCED->SUSPECT->SYNCED, alarm0 never set.
REQ-035 Loss: gemB_synced low for 10 cycles (LOST_THRESH=8) -> alarm1 rises on the 8th bad cycle and alarm_latched1 sets; gemB_synced then high for 16 cycles -> SYNCED, alarm1=0, alarm_latched1=1.
REQ-036 Recover interrupted: from LOST, 5 good cycles then 1 bad cycle -> back to LOST; cnt_episode2 increments by 1 for that bad cycle.
REQ-037 Saturation: preload cnt_bad0=2^24-2 (force), hold gemA_synced low for 5 cycles -> counter stops at 0xFFFFFF.
REQ-038 Clear collision: assert ctr_clear in the same cycle as an episode edge -> all counters read 0 next cycle; count_en=0 for 4 bad cycles -> counters unchanged but FSM still advances.
REQ-039 Async reset: pull global_reset_n low mid-LOST, between clock edges -> outputs zero immediately; after release with synced inputs high, no count occurs.
